bitset_iterator: RTL
====================

Name: bitset_iterator

Overview:
Streams the positions of all set bits in an accepted bit vector, one index per cycle, over a valid/ready handshake. Order is lowest-first or highest-first, selected by MODE. It generalises the combinational first-set/zero-count function into a sequential walker. Consumers include dispatch, writeback-arbitration and free-list logic that must service every pending request rather than only the first one.

Parameters:
WIDTH, 8, width of the input vector (>=1).
MODE, 0, 0 = emit from LSB upward (trailing order); 1 = emit from MSB downward (leading order).
IDX_W, max(1,$clog2(WIDTH)), derived localparam; width of idx_o and seq_o. Not overridable.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  asynchronous active-low reset.
flush_i  in  1  synchronous abort of the current vector.
vec_valid_i  in  1  input vector valid.
vec_ready_o  out  1  block can accept a vector this cycle.
vec_i  in  WIDTH  bit vector to iterate.
idx_valid_o  out  1  idx_o/last_o/seq_o valid.
idx_ready_i  in  1  consumer accepts the index.
idx_o  out  IDX_W  position of the current set bit in vec_i's native bit numbering (MODE only changes order).
last_o  out  1  current index is the final set bit of the vector.
seq_o  out  IDX_W  beat number within the vector (0,1,2,...).
zero_o  out  1  one-cycle pulse: an all-zero vector was accepted and dropped.

Behaviour:
- Reset (rst_ni=0, async): state IDLE, pending='0, seq='0. Outputs: vec_ready_o=1, idx_valid_o=0, idx_o=0, last_o=0, seq_o=0, zero_o=0.
- State IDLE:
  - vec_ready_o=1, idx_valid_o=0.
  - Accept on vec_valid_i&vec_ready_o.
  - vec_i!=0: pending<=vec_i, seq<=0, go ITER.
  - vec_i==0: stay IDLE, zero_o=1 on the next cycle only.
- State ITER:
  - idx_valid_o=1; idx_o = first set bit of pending per MODE (combinational).
  - last_o = (pending with idx_o bit cleared)==0; seq_o=seq.
- Beat handshake (idx_valid_o&idx_ready_i):
  - Clear bit idx_o in pending; seq<=seq+1.
  - If last_o: go IDLE, unless a new vector is accepted in the same cycle.
- Back-to-back: in ITER, vec_ready_o = last_o & idx_ready_i (combinational path from idx_ready_i, documented). New vector accepted on the final beat loads pending/seq=0 and stays ITER. If it is zero: go IDLE and pulse zero_o.
- Latency: first index valid one cycle after vector acceptance. Throughput is one index per cycle with idx_ready_i held high, i.e. popcount(vec) cycles per vector.
- Backpressure: while idx_valid_o&!idx_ready_i, idx_o, last_o and seq_o hold stable. vec_ready_o=0 except on the final-beat handshake.
- flush_i: highest priority. Next cycle state IDLE, pending='0, seq=0, no zero_o pulse. A vector presented in the flush cycle is not accepted (vec_ready_o forced 0 that cycle).
- WIDTH=1: idx_o always 0; every non-zero vector is a single beat with last_o=1.
- seq_o width IDX_W: wrap is impossible except at WIDTH a power of two with all bits set. There the last beat has seq=WIDTH-1, so no overflow occurs.
- Reset mid-iteration: outputs return to reset values immediately (async). Any partial vector is lost.
- No X on outputs when idx_valid_o=0: idx_o, last_o and seq_o are driven 0 in IDLE.

Decomposition:
- Shared package: iter_order_e enum (ORDER_LSB_FIRST=0, ORDER_MSB_FIRST=1), used for MODE.
- Sub-module: one instance of the existing lzc leading/trailing zero counter on pending, with MODE passed through. Its count is converted to a bit position: idx = cnt for MODE=0, WIDTH-1-cnt for MODE=1. Its empty_o is used as an assertion check (never set in ITER).
- last_o: compute as (pending & (pending-1))==0 for MODE=0, and the equivalent cleared-bit test for MODE=1. No second encoder instance.
- FSM, pending register and seq counter live in the top module.

Test Plan:
- WIDTH=8, MODE=0, vec_i=8'hA4, idx_ready_i=1 -> idx_o 2,5,7 on 3 consecutive cycles, seq_o 0,1,2, last_o only with 7, then vec_ready_o=1.
- Same with MODE=1 -> idx_o 7,5,2, last_o with 2.
- vec_i=8'h00 accepted -> zero_o=1 for exactly one cycle, idx_valid_o stays 0, vec_ready_o stays 1.
- vec_i=8'h0C, idx_ready_i low 3 cycles on first beat -> idx_o=2/seq_o=0 held stable 3 cycles, then 3 with last_o=1.
- vec_i=8'h80 then 8'h01 held valid during the final beat -> second vector accepted in that cycle, next cycle idx_o=0, seq_o=0, no idle bubble.
- vec_i=8'hFF, flush_i after 2 beats -> next cycle idx_valid_o=0, vec_ready_o=1, zero_o=0. Repeat with rst_ni pulsed mid-vector -> outputs at reset values immediately.

Source files
------------

// File: rtl/bitset_iterator_pkg.sv
// bitset_iterator_pkg: iteration order and walker states shared by the bitset iterator files
package bitset_iterator_pkg;
    typedef enum logic {ORDER_LSB_FIRST = 1'b0, ORDER_MSB_FIRST = 1'b1} iter_order_e;
    typedef enum logic {IDLE = 1'b0, ITER = 1'b1} iter_state_e;
endpackage

// File: rtl/bitset_iterator_lzc.sv
// bitset_iterator_lzc: trailing-zero (LSB first) or leading-zero (MSB first) counter
module bitset_iterator_lzc
    import bitset_iterator_pkg::*;
#(
    parameter int          WIDTH = 8,
    parameter iter_order_e MODE  = ORDER_LSB_FIRST,
    localparam int         CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             empty_o
);
    always_comb begin
        cnt_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (MODE == ORDER_LSB_FIRST && in_i[i]) cnt_o = CNT_W'(i);
        for (int i = 0; i < WIDTH; i++)
            if (MODE == ORDER_MSB_FIRST && in_i[i]) cnt_o = CNT_W'(WIDTH - 1 - i);
        empty_o = (in_i == '0);
    end
endmodule

// File: rtl/bitset_iterator.sv
// bitset_iterator: streams the positions of all set bits of an accepted vector, one per cycle
module bitset_iterator
    import bitset_iterator_pkg::*;
#(
    parameter int          WIDTH = 8,
    parameter iter_order_e MODE  = ORDER_LSB_FIRST,
    localparam int         IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             vec_valid_i,
    output logic             vec_ready_o,
    input  logic [WIDTH-1:0] vec_i,
    output logic             idx_valid_o,
    input  logic             idx_ready_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             last_o,
    output logic [IDX_W-1:0] seq_o,
    output logic             zero_o
);
    iter_state_e      state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d, cleared;
    logic [IDX_W-1:0] seq_q, seq_d, cnt, idx;
    logic             zero_q, zero_d, empty, iter, beat, accept;

    bitset_iterator_lzc #(.WIDTH(WIDTH), .MODE(MODE)) u_lzc (
        .in_i    (pending_q),
        .cnt_o   (cnt),
        .empty_o (empty)
    );

    always_comb begin
        idx = (MODE == ORDER_LSB_FIRST) ? cnt : IDX_W'(WIDTH - 1) - cnt;
        cleared = (MODE == ORDER_LSB_FIRST) ? pending_q & (pending_q - WIDTH'(1))
                                            : pending_q & ~(WIDTH'(1) << idx);
        iter = (state_q == ITER);
        idx_valid_o = iter;
        idx_o = iter ? idx : '0;
        last_o = iter && (cleared == '0);
        seq_o = iter ? seq_q : '0;
        zero_o = zero_q;
        // ready follows idx_ready_i combinationally so the next vector loads on the final beat
        vec_ready_o = !flush_i && (!iter || (last_o && idx_ready_i));
        beat = iter && idx_ready_i;
        accept = vec_valid_i && vec_ready_o;
        state_d = state_q;
        pending_d = pending_q;
        seq_d = seq_q;
        zero_d = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
            pending_d = '0;
            seq_d = '0;
        end else if (accept) begin
            state_d = (vec_i != '0) ? ITER : IDLE;
            pending_d = vec_i;
            seq_d = '0;
            zero_d = (vec_i == '0);
        end else if (beat) begin
            state_d = last_o ? IDLE : ITER;
            pending_d = cleared;
            seq_d = seq_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pending_q <= '0;
            seq_q <= '0;
            zero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pending_q <= pending_d;
            seq_q <= seq_d;
            zero_q <= zero_d;
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni) iter |-> !empty);
endmodule
